// File: rtl/alu_pkg.sv
// Shared definitions for the A09 ALU: function codes and status flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_ASR  = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_ADC  = 4'd11,
    ALU_SBC  = 4'd12,
    ALU_CMP  = 4'd13,
    ALU_MOVB = 4'd14,
    ALU_NOP  = 4'd15
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor. Subtraction is A + ~B + cin; the caller picks cin
// (1 for SUB/CMP, ~C for SBC) and turns carry-out into borrow.
module alu_addsub #(
  parameter int DataWidth = 16
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic                 sub_i,
  input  logic                 cin_i,
  output logic [DataWidth-1:0] sum_o,
  output logic                 cout_o,
  output logic                 ovf_o
);

  localparam int Msb = DataWidth - 1;

  logic [DataWidth-1:0] b_eff;
  logic [DataWidth:0]   sum_ext;

  assign b_eff   = sub_i ? ~b_i : b_i;
  assign sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{DataWidth{1'b0}}, cin_i};
  assign sum_o   = sum_ext[Msb:0];
  assign cout_o  = sum_ext[DataWidth];
  // With B already inverted for subtraction, one overflow rule covers both.
  assign ovf_o   = (a_i[Msb] == b_eff[Msb]) && (sum_ext[Msb] != a_i[Msb]);

endmodule

// File: rtl/alu.sv
// Registered A09 ALU: function mux and flag update, result and flags one clock later.
module alu
  import alu_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [3:0]           flags_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [3:0]           func_op_i,
  output logic [DataWidth-1:0] y_o,
  output logic [3:0]           flags_o
);

  localparam int Msb = DataWidth - 1;

  alu_op_e              op;
  logic                 c_in;
  logic                 as_sub, as_cin, as_cout, as_ovf;
  logic [DataWidth-1:0] as_sum;
  logic [DataWidth-1:0] y_d, y_q, zn_src;
  logic [3:0]           flags_d, flags_q;
  logic                 c_d, v_d;

  assign op   = alu_op_e'(func_op_i);
  assign c_in = flags_i[FLAG_C];

  always_comb begin
    as_sub = 1'b0;
    as_cin = 1'b0;
    unique case (op)
      ALU_ADC:          as_cin = c_in;
      ALU_SUB, ALU_CMP: begin as_sub = 1'b1; as_cin = 1'b1;  end
      ALU_SBC:          begin as_sub = 1'b1; as_cin = ~c_in; end
      default:          ;
    endcase
  end

  alu_addsub #(.DataWidth(DataWidth)) u_addsub (
    .a_i    (a_i),
    .b_i    (b_i),
    .sub_i  (as_sub),
    .cin_i  (as_cin),
    .sum_o  (as_sum),
    .cout_o (as_cout),
    .ovf_o  (as_ovf)
  );

  always_comb begin
    y_d = a_i;
    c_d = c_in;
    v_d = flags_i[FLAG_V];
    unique case (op)
      ALU_ADD, ALU_ADC: begin y_d = as_sum; c_d = as_cout;  v_d = as_ovf; end
      ALU_SUB, ALU_SBC: begin y_d = as_sum; c_d = ~as_cout; v_d = as_ovf; end
      ALU_CMP:          begin y_d = a_i;    c_d = ~as_cout; v_d = as_ovf; end
      ALU_AND:  y_d = a_i & b_i;
      ALU_OR:   y_d = a_i | b_i;
      ALU_XOR:  y_d = a_i ^ b_i;
      ALU_NOT:  y_d = ~a_i;
      ALU_SHL:  begin y_d = {a_i[Msb-1:0], 1'b0};     c_d = a_i[Msb]; end
      ALU_SHR:  begin y_d = {1'b0, a_i[Msb:1]};       c_d = a_i[0];   end
      ALU_ASR:  begin y_d = {a_i[Msb], a_i[Msb:1]};   c_d = a_i[0];   end
      ALU_ROL:  begin y_d = {a_i[Msb-1:0], c_in};     c_d = a_i[Msb]; end
      ALU_ROR:  begin y_d = {c_in, a_i[Msb:1]};       c_d = a_i[0];   end
      ALU_MOVB: y_d = b_i;
      ALU_NOP:  y_d = a_i;
      default:  ;
    endcase

    // CMP returns A but reports Z/N of the difference.
    zn_src = (op == ALU_CMP) ? as_sum : y_d;

    flags_d         = 4'b0000;
    flags_d[FLAG_Z] = (zn_src == '0);
    flags_d[FLAG_N] = zn_src[Msb];
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
    if (op == ALU_NOP) flags_d = flags_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      y_q     <= '0;
      flags_q <= 4'b0000;
    end else begin
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign y_o     = y_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes hand-computed results, the monitor checks one edge later.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  f;
    string       name;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  flags_i = 4'b0000;
  logic [15:0] a_i = 16'h0000;
  logic [15:0] b_i = 16'h0000;
  logic [3:0]  func_op_i = 4'd0;
  logic [15:0] y_o;
  logic [3:0]  flags_o;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu #(.DataWidth(16)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flags_i   (flags_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .func_op_i (func_op_i),
    .y_o       (y_o),
    .flags_o   (flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; expected result is due at the next rising edge.
  task automatic issue(input logic rst, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] fi,
                       input logic [15:0] ey, input logic [3:0] ef, input string nm);
    exp_t e;
    @(negedge clk_i);
    reset_i   = rst;
    func_op_i = op;
    a_i       = a;
    b_i       = b;
    flags_i   = fi;
    e.y = ey; e.f = ef; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (y_o !== e.y || flags_o !== e.f) begin
          fails++;
          $display("FAIL %s: got y=%h flags=%b, expected y=%h flags=%b",
                   e.name, y_o, flags_o, e.y, e.f);
        end
      end
    end
  end

  initial begin : driver
    //     rst   op        a         b         fi       exp_y     exp_f    name
    issue(1'b1, ALU_ADD,  16'h1234, 16'h5678, 4'b1111, 16'h0000, 4'b0000, "reset");
    issue(1'b0, ALU_ADD,  16'h0003, 16'h0004, 4'b0000, 16'h0007, 4'b0000, "add_3_4");
    issue(1'b0, ALU_ADD,  16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, "add_wrap");
    issue(1'b0, ALU_ADD,  16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 4'b1100, "add_ovf");
    issue(1'b0, ALU_ADC,  16'h0001, 16'h0001, 4'b0010, 16'h0003, 4'b0000, "adc_cin");
    issue(1'b0, ALU_ADC,  16'hFFFF, 16'h0000, 4'b0010, 16'h0000, 4'b0011, "adc_wrap");
    issue(1'b0, ALU_SUB,  16'h0005, 16'h0005, 4'b0000, 16'h0000, 4'b0001, "sub_zero");
    issue(1'b0, ALU_SUB,  16'h0000, 16'h0001, 4'b0000, 16'hFFFF, 4'b0110, "sub_borrow");
    issue(1'b0, ALU_SUB,  16'h8000, 16'h0001, 4'b0000, 16'h7FFF, 4'b1000, "sub_ovf");
    issue(1'b0, ALU_SBC,  16'h0005, 16'h0002, 4'b0010, 16'h0002, 4'b0000, "sbc_cin");
    issue(1'b0, ALU_SBC,  16'h0000, 16'h0000, 4'b0010, 16'hFFFF, 4'b0110, "sbc_borrow");
    issue(1'b0, ALU_CMP,  16'h0002, 16'h0003, 4'b0000, 16'h0002, 4'b0110, "cmp_lt");
    issue(1'b0, ALU_AND,  16'hF0F0, 16'h0FF0, 4'b1010, 16'h00F0, 4'b1010, "and_keep_cv");
    issue(1'b0, ALU_OR,   16'h00F0, 16'h0F00, 4'b0000, 16'h0FF0, 4'b0000, "or");
    issue(1'b0, ALU_XOR,  16'hFFFF, 16'hFFFF, 4'b0100, 16'h0000, 4'b0001, "xor_zero");
    issue(1'b0, ALU_NOT,  16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 4'b0100, "not");
    issue(1'b0, ALU_SHL,  16'h8001, 16'h0000, 4'b0000, 16'h0002, 4'b0010, "shl");
    issue(1'b0, ALU_SHR,  16'h8001, 16'h0000, 4'b0000, 16'h4000, 4'b0010, "shr");
    issue(1'b0, ALU_ASR,  16'h8002, 16'h0000, 4'b0000, 16'hC001, 4'b0100, "asr");
    issue(1'b0, ALU_ROL,  16'h8000, 16'h0000, 4'b0010, 16'h0001, 4'b0010, "rol_cin");
    issue(1'b0, ALU_ROR,  16'h0001, 16'h0000, 4'b0000, 16'h0000, 4'b0011, "ror");
    issue(1'b0, ALU_MOVB, 16'h5555, 16'h1234, 4'b1000, 16'h1234, 4'b1000, "movb");
    issue(1'b0, ALU_NOP,  16'hABCD, 16'h0000, 4'b1111, 16'hABCD, 4'b1111, "nop");
    issue(1'b1, ALU_ADD,  16'h0001, 16'h0001, 4'b0000, 16'h0000, 4'b0000, "reset_midstream");
    issue(1'b0, ALU_ADD,  16'h0001, 16'h0001, 4'b0000, 16'h0002, 4'b0000, "add_after_reset");
    repeat (3) @(posedge clk_i);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
